// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, datapath select encodings, controller states
// and the packed control word driven by the multi-cycle controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OP_AND   = 3'b011;
    localparam logic [2:0] ALU_OP_OR    = 3'b100;

    localparam logic [1:0] ALUSRCB_RT     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_RTYPE_EX = 4'd2,
        S_RTYPE_WB = 4'd3,
        S_MEM_ADR  = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_ADDI_EX  = 4'd8,
        S_ANDI_EX  = 4'd9,
        S_ORI_EX   = 4'd10,
        S_IMM_WB   = 4'd11,
        S_BRANCH   = 4'd12,
        S_JUMP     = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_output_decode.sv
// State -> control-word decoder for the multi-cycle controller; write enables are
// suppressed while reset is high and the FETCH loads wait on mem_ready.
module mc_output_decode
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic [5:0]         op_code,
    input  logic               mem_ready,
    input  logic               reset,
    output logic [CTRL_W-1:0]  ctrl
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (state)
            STATE_W'(S_FETCH): begin
                c.mem_read  = 1'b1;
                c.alu_src_b = ALUSRCB_FOUR;
                c.alu_op    = ALU_OP_ADD;
                c.pc_src    = PCSRC_ALU;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
            end
            STATE_W'(S_DECODE): begin
                c.alu_src_b = ALUSRCB_IMM_SH;
                c.alu_op    = ALU_OP_ADD;
            end
            STATE_W'(S_RTYPE_EX): begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_RT;
                c.alu_op    = ALU_OP_FUNCT;
            end
            STATE_W'(S_RTYPE_WB): begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            STATE_W'(S_MEM_ADR): begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            STATE_W'(S_MEM_RD): begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            STATE_W'(S_MEM_WB): begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            STATE_W'(S_MEM_WR): begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            STATE_W'(S_ADDI_EX), STATE_W'(S_ANDI_EX), STATE_W'(S_ORI_EX): begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                if (state == STATE_W'(S_ANDI_EX))
                    c.alu_op = ALU_OP_AND;
                else if (state == STATE_W'(S_ORI_EX))
                    c.alu_op = ALU_OP_OR;
                else
                    c.alu_op = ALU_OP_ADD;
            end
            STATE_W'(S_IMM_WB): begin
                c.reg_write = 1'b1;
            end
            STATE_W'(S_BRANCH): begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = ALUSRCB_RT;
                c.alu_op        = ALU_OP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PCSRC_ALUOUT;
                c.branch_ne     = (op_code == OP_BNE);
            end
            STATE_W'(S_JUMP): begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
            end
            STATE_W'(S_ILLEGAL): begin
                c.illegal_op = 1'b1;
            end
            default: c = '0;
        endcase

        // Reset may land mid-access; no architectural write may escape that cycle.
        if (reset) begin
            c.ir_write      = 1'b0;
            c.pc_write      = 1'b0;
            c.pc_write_cond = 1'b0;
            c.reg_write     = 1'b0;
            c.mem_write     = 1'b0;
        end
    end

    assign ctrl = c;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: state register and next-state logic, with the
// control word decoded from the current state by mc_output_decode.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int STATE_W       = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op_code,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               mem_rdy;
    logic [CTRL_W-1:0]  ctrl_bits;
    ctrl_t              ctrl;

    assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        state_d = STATE_W'(S_FETCH);
        case (state_q)
            STATE_W'(S_FETCH):    state_d = mem_rdy ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            STATE_W'(S_DECODE): begin
                case (op_code)
                    OP_RTYPE:      state_d = STATE_W'(S_RTYPE_EX);
                    OP_LW, OP_SW:  state_d = STATE_W'(S_MEM_ADR);
                    OP_ADDI:       state_d = STATE_W'(S_ADDI_EX);
                    OP_ANDI:       state_d = STATE_W'(S_ANDI_EX);
                    OP_ORI:        state_d = STATE_W'(S_ORI_EX);
                    OP_BEQ, OP_BNE: state_d = STATE_W'(S_BRANCH);
                    OP_J:          state_d = STATE_W'(S_JUMP);
                    default:       state_d = STATE_W'(S_ILLEGAL);
                endcase
            end
            STATE_W'(S_RTYPE_EX): state_d = STATE_W'(S_RTYPE_WB);
            STATE_W'(S_MEM_ADR):  state_d = (op_code == OP_LW) ? STATE_W'(S_MEM_RD) : STATE_W'(S_MEM_WR);
            STATE_W'(S_MEM_RD):   state_d = mem_rdy ? STATE_W'(S_MEM_WB) : STATE_W'(S_MEM_RD);
            STATE_W'(S_MEM_WR):   state_d = mem_rdy ? STATE_W'(S_FETCH) : STATE_W'(S_MEM_WR);
            STATE_W'(S_ADDI_EX), STATE_W'(S_ANDI_EX), STATE_W'(S_ORI_EX):
                                  state_d = STATE_W'(S_IMM_WB);
            default:              state_d = STATE_W'(S_FETCH);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= STATE_W'(S_FETCH);
        else
            state_q <= state_d;
    end

    mc_output_decode #(
        .STATE_W (STATE_W)
    ) u_decode (
        .state     (state_q),
        .op_code   (op_code),
        .mem_ready (mem_rdy),
        .reset     (reset),
        .ctrl      (ctrl_bits)
    );

    assign ctrl          = ctrl_t'(ctrl_bits);
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign illegal_op    = ctrl.illegal_op;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each instruction class is walked cycle by
// cycle and the control word is compared against hand-derived values.
module tb_multicycle_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op_code;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state_dbg;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    multicycle_control #(
        .STATE_W       (4),
        .MEM_HANDSHAKE (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op_code       (op_code),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .illegal_op    (illegal_op),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 2 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_state(input string tag, input state_e s);
        check(tag, int'(state_dbg), int'(s));
    endtask

    task automatic chk_no_writes(input string tag);
        check({tag, ".reg_write"}, int'(reg_write), 0);
        check({tag, ".mem_write"}, int'(mem_write), 0);
    endtask

    initial begin
        reset     = 1'b1;
        op_code   = OP_RTYPE;
        mem_ready = 1'b1;

        // Power-on reset
        tick();
        tick();
        chk_state("por.state", S_FETCH);
        check("por.ir_write", int'(ir_write), 0);
        check("por.pc_write", int'(pc_write), 0);
        check("por.mem_read", int'(mem_read), 1);
        check("por.alu_src_b", int'(alu_src_b), int'(ALUSRCB_FOUR));
        chk_no_writes("por");
        reset = 1'b0;
        #1;
        check("fetch.ir_write", int'(ir_write), 1);
        check("fetch.pc_write", int'(pc_write), 1);

        // lw with mem_ready high: 5 cycles
        op_code = OP_LW;
        tick();
        chk_state("lw.c2", S_DECODE);
        check("lw.dec.alu_src_b", int'(alu_src_b), int'(ALUSRCB_IMM_SH));
        check("lw.dec.ir_write", int'(ir_write), 0);
        tick();
        chk_state("lw.c3", S_MEM_ADR);
        check("lw.adr.alu_src_b", int'(alu_src_b), int'(ALUSRCB_IMM));
        check("lw.adr.alu_src_a", int'(alu_src_a), 1);
        chk_no_writes("lw.c3");
        tick();
        chk_state("lw.c4", S_MEM_RD);
        check("lw.rd.mem_read", int'(mem_read), 1);
        check("lw.rd.iord", int'(iord), 1);
        chk_no_writes("lw.c4");
        tick();
        chk_state("lw.c5", S_MEM_WB);
        check("lw.wb.reg_write", int'(reg_write), 1);
        check("lw.wb.mem_to_reg", int'(mem_to_reg), 1);
        check("lw.wb.reg_dst", int'(reg_dst), 0);
        tick();
        chk_state("lw.c6", S_FETCH);

        // Reset applied for two cycles in the middle of a MEM_RD stall
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk_state("rst.memrd", S_MEM_RD);
        tick();
        chk_state("rst.stall", S_MEM_RD);
        check("rst.stall.mem_read", int'(mem_read), 1);
        reset = 1'b1;
        #1;
        chk_no_writes("rst.hi0");
        tick();
        chk_state("rst.hi1", S_FETCH);
        check("rst.hi1.ir_write", int'(ir_write), 0);
        chk_no_writes("rst.hi1");
        tick();
        chk_state("rst.hi2", S_FETCH);
        mem_ready = 1'b1;
        #1;
        check("rst.hi2.pc_write", int'(pc_write), 0);
        reset = 1'b0;
        op_code = OP_SW;
        #1;
        check("rst.rel.ir_write", int'(ir_write), 1);
        check("rst.rel.pc_write", int'(pc_write), 1);
        tick();
        chk_state("rst.dec", S_DECODE);
        check("rst.dec.ir_write", int'(ir_write), 0);
        check("rst.dec.pc_write", int'(pc_write), 0);

        // sw with mem_ready low for 3 cycles in MEM_WR
        tick();
        chk_state("sw.adr", S_MEM_ADR);
        mem_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk_state("sw.wr.stall", S_MEM_WR);
            check("sw.wr.mem_write", int'(mem_write), 1);
            check("sw.wr.iord", int'(iord), 1);
            check("sw.wr.reg_write", int'(reg_write), 0);
        end
        mem_ready = 1'b1;
        #1;
        chk_state("sw.wr.last", S_MEM_WR);
        check("sw.wr.last.mem_write", int'(mem_write), 1);
        check("sw.wr.last.iord", int'(iord), 1);
        tick();
        chk_state("sw.done", S_FETCH);
        check("sw.done.reg_write", int'(reg_write), 0);

        // bne: 3 cycles
        op_code = OP_BNE;
        tick();
        chk_state("bne.dec", S_DECODE);
        tick();
        chk_state("bne.br", S_BRANCH);
        check("bne.pc_write_cond", int'(pc_write_cond), 1);
        check("bne.branch_ne", int'(branch_ne), 1);
        check("bne.alu_op", int'(alu_op), int'(ALU_OP_SUB));
        check("bne.pc_src", int'(pc_src), int'(PCSRC_ALUOUT));
        check("bne.alu_src_b", int'(alu_src_b), int'(ALUSRCB_RT));
        tick();
        chk_state("bne.done", S_FETCH);

        // beq
        op_code = OP_BEQ;
        tick();
        tick();
        chk_state("beq.br", S_BRANCH);
        check("beq.branch_ne", int'(branch_ne), 0);
        check("beq.pc_write_cond", int'(pc_write_cond), 1);
        tick();
        chk_state("beq.done", S_FETCH);

        // ori: 4 cycles
        op_code = OP_ORI;
        tick();
        tick();
        chk_state("ori.ex", S_ORI_EX);
        check("ori.alu_op", int'(alu_op), int'(ALU_OP_OR));
        check("ori.alu_src_b", int'(alu_src_b), int'(ALUSRCB_IMM));
        check("ori.alu_src_a", int'(alu_src_a), 1);
        tick();
        chk_state("ori.wb", S_IMM_WB);
        check("ori.wb.reg_write", int'(reg_write), 1);
        check("ori.wb.reg_dst", int'(reg_dst), 0);
        check("ori.wb.mem_to_reg", int'(mem_to_reg), 0);
        tick();
        chk_state("ori.done", S_FETCH);

        // andi / addi execute ALU ops
        op_code = OP_ANDI;
        tick();
        tick();
        check("andi.alu_op", int'(alu_op), int'(ALU_OP_AND));
        tick();
        tick();
        op_code = OP_ADDI;
        tick();
        tick();
        chk_state("addi.ex", S_ADDI_EX);
        check("addi.alu_op", int'(alu_op), int'(ALU_OP_ADD));
        tick();
        tick();
        chk_state("addi.done", S_FETCH);

        // R-type: 4 cycles
        op_code = OP_RTYPE;
        tick();
        tick();
        chk_state("rt.ex", S_RTYPE_EX);
        check("rt.alu_op", int'(alu_op), int'(ALU_OP_FUNCT));
        tick();
        chk_state("rt.wb", S_RTYPE_WB);
        check("rt.reg_dst", int'(reg_dst), 1);
        check("rt.reg_write", int'(reg_write), 1);
        tick();
        chk_state("rt.done", S_FETCH);

        // j: 3 cycles
        op_code = OP_J;
        tick();
        tick();
        chk_state("j.jump", S_JUMP);
        check("j.pc_write", int'(pc_write), 1);
        check("j.pc_src", int'(pc_src), int'(PCSRC_JUMP));
        tick();
        chk_state("j.done", S_FETCH);

        // Unsupported opcode: one-cycle illegal_op pulse, no writes
        op_code = 6'h3F;
        check("ill.fetch.illegal_op", int'(illegal_op), 0);
        tick();
        chk_state("ill.dec", S_DECODE);
        check("ill.dec.illegal_op", int'(illegal_op), 0);
        tick();
        chk_state("ill.st", S_ILLEGAL);
        check("ill.illegal_op", int'(illegal_op), 1);
        check("ill.pc_write", int'(pc_write), 0);
        check("ill.mem_read", int'(mem_read), 0);
        chk_no_writes("ill");
        tick();
        chk_state("ill.done", S_FETCH);
        check("ill.done.illegal_op", int'(illegal_op), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle main controller for the MIPS datapath. It sequences one instruction through fetch, decode, execute, memory and writeback over 3-5+ cycles. It drives every datapath enable/select from a state register, with wait-state stalls on a memory ready handshake. It sits beside the shared ALU/memory datapath and replaces single-cycle decode for the multi-cycle build.

Parameters:
STATE_W, 4, width of state register / state_dbg port
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready treated as constant 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op_code  in  6  instruction opcode IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition true
branch_ne  out  1  0 = condition is zero flag (BEQ), 1 = condition is !zero (BNE)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR
reg_dst  out  1  dest reg: 0 = rt, 1 = rd
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_op  out  3  000 add, 001 sub, 010 funct-decoded, 011 and, 100 or
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse on unsupported opcode
state_dbg  out  STATE_W  current state encoding

Behaviour:
- Moore outputs decoded from state. Exceptions: ir_write/pc_write in FETCH, and state advance in memory states, are gated by mem_ready.
- All outputs not listed for a state are 0.
- States and outputs:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00. ir_write=pc_write=mem_ready. Stay while !mem_ready, else -> DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target to ALUOut). Dispatch on op_code:
    - 0x00 -> RTYPE_EX
    - 0x23, 0x2B -> MEM_ADR
    - 0x08 -> ADDI_EX
    - 0x0C -> ANDI_EX
    - 0x0D -> ORI_EX
    - 0x04, 0x05 -> BRANCH
    - 0x02 -> JUMP
    - other -> ILLEGAL
  - RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=010 -> RTYPE_WB.
  - RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=000. Next state is MEM_RD if op_code==0x23, else MEM_WR.
  - MEM_RD: mem_read=1, iord=1. Stay while !mem_ready, else -> MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
  - MEM_WR: mem_write=1, iord=1. Stay while !mem_ready, else -> FETCH.
  - ADDI_EX / ANDI_EX / ORI_EX: alu_src_a=1, alu_src_b=10, alu_op=000/011/100 respectively -> IMM_WB.
  - IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01, branch_ne=(op_code==0x05) -> FETCH.
  - JUMP: pc_write=1, pc_src=10 -> FETCH.
  - ILLEGAL: illegal_op=1, no writes -> FETCH (instruction skipped, PC already incremented).
- Requests in memory states are held stable (mem_read/mem_write, iord) until the mem_ready cycle inclusive.
- Cycle counts with mem_ready tied high:
  - lw = 5
  - R-type, sw, addi, andi, ori = 4
  - beq, bne, j = 3
  - illegal = 3
- Reset:
  - Synchronous; state<=FETCH on any clk edge with reset=1, regardless of current state, including mid-stall.
  - Outputs then show FETCH decode; ir_write/pc_write are forced 0 while reset=1.
  - No write (reg_write/mem_write) may assert in the cycle reset is high.
- Unused state encodings -> FETCH next cycle; all outputs 0 while in them.
- MEM_HANDSHAKE=0: mem_ready internally tied 1; the port is ignored.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams: OP_RTYPE 0x00, OP_ADDI 0x08, OP_LW 0x23, OP_SW 0x2B, OP_ANDI 0x0C, OP_ORI 0x0D, OP_BEQ 0x04, OP_BNE 0x05, OP_J 0x02
  - ALU_OP_* and ALUSRCB_*/PCSRC_* encodings
  - state enum
- Natural sub-module: mc_output_decode (pure state -> control-word decoder); next-state logic stays in the top.

Test Plan:
- reset=1 for 2 cycles mid-MEM_RD stall, then release -> state_dbg=FETCH, no reg_write/mem_write during reset, first fetch with mem_ready=1 gives ir_write=pc_write=1 for exactly one cycle.
- op_code=0x23, mem_ready=1 -> states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB; reg_write=1, mem_to_reg=1, reg_dst=0 only in cycle 5.
- op_code=0x2B, mem_ready low 3 cycles in MEM_WR -> mem_write=1, iord=1 held 4 cycles, then FETCH; reg_write never 1.
- op_code=0x05 -> BRANCH cycle has pc_write_cond=1, branch_ne=1, alu_op=001, pc_src=01; op_code=0x04 gives branch_ne=0.
- op_code=0x0D -> ORI_EX alu_op=100, alu_src_b=10, then IMM_WB with reg_write=1, reg_dst=0; total 4 cycles.
- op_code=0x3F -> illegal_op pulses exactly 1 cycle, no writes, returns to FETCH 3 cycles after the previous FETCH.
